// File: rtl/bicubic_window_buffer.sv
// Bicubic 4x4 neighbourhood buffer: five rotating line buffers feed a border-clamped
// window that is offered OUT_PER_WIN times per source pixel, in raster order.
module bicubic_window_buffer #(
    parameter int DW          = 24,
    parameter int IMG_W       = 960,
    parameter int IMG_H       = 540,
    parameter int OUT_PER_WIN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [16*DW-1:0] m_win,
    output logic [9:0]       m_row,
    output logic [9:0]       m_col,
    output logic [3:0]       m_sub,
    output logic             m_frame_end
);
    // state | meaning
    // FILL  | accepting pixels until window (0,0) has its dependency
    // RUN   | windows emitted while the frame streams in
    // DRAIN | frame fully received; bottom/right windows emitted from storage
    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    localparam int NR   = 5;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int LEAD = 3 * IMG_W + 5;
    localparam int AW   = $clog2(IMG_W * IMG_H + LEAD + 1) + 1;
    localparam logic [CW-1:0] LAST_C    = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R    = RW'(IMG_H - 1);
    localparam logic [3:0]    SUB_LAST  = 4'(OUT_PER_WIN - 1);
    localparam logic [RW+1:0] ROW_AHEAD = (RW + 2)'(3);
    localparam logic [AW-1:0] IDX_AHEAD = AW'(LEAD);

    state_t          state, state_nxt;
    logic [DW-1:0]   mem [NR][IMG_W];
    logic [CW-1:0]   in_c, out_c, dep_c;
    logic [RW-1:0]   in_r, out_r, dep_r;
    logic [2:0]      wr_slot, out_slot;
    logic [AW-1:0]   in_idx, out_idx;
    logic [3:0]      sub;
    logic            rdy_en, frame_end_q;
    logic            in_hs, out_hs, last_in, last_win, win_adv, dep_ok;
    logic [2:0]      rs [4];
    logic [CW-1:0]   cs [4];

    function automatic logic [2:0] slot_add(input logic [2:0] s, input logic [2:0] k);
        logic [3:0] t;
        t = {1'b0, s} + {1'b0, k};
        if (t >= 4'd5) t = t - 4'd5;
        return t[2:0];
    endfunction

    // The gating pixel of window (r,c) is (r+2,c+2), clamped into the frame.
    assign dep_r  = (out_r >= LAST_R - RW'(1)) ? LAST_R : out_r + RW'(2);
    assign dep_c  = (out_c >= LAST_C - CW'(1)) ? LAST_C : out_c + CW'(2);
    assign dep_ok = (in_r > dep_r) || ((in_r == dep_r) && (in_c > dep_c));

    assign m_valid = (state == DRAIN) || ((state == RUN) && dep_ok);
    // Row r+3 reuses the slot of row r-2, which no pending window touches.
    assign s_ready = rdy_en && (state != DRAIN)
                     && ({2'b0, in_r} <= {2'b0, out_r} + ROW_AHEAD)
                     && (in_idx <= out_idx + IDX_AHEAD);

    assign in_hs    = s_valid && s_ready;
    assign out_hs   = m_valid && m_ready;
    assign last_in  = in_hs && (in_r == LAST_R) && (in_c == LAST_C);
    assign last_win = (out_r == LAST_R) && (out_c == LAST_C);
    assign win_adv  = out_hs && (sub == SUB_LAST);

    assign m_row       = 10'(out_r);
    assign m_col       = 10'(out_c);
    assign m_sub       = sub;
    assign m_frame_end = frame_end_q;

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_in) state_nxt = DRAIN;
                     else if (dep_ok) state_nxt = RUN;
            RUN:     if (last_in) state_nxt = DRAIN;
            DRAIN:   if (win_adv && last_win) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            rdy_en      <= 1'b0;
            frame_end_q <= 1'b0;
            in_r        <= '0;
            in_c        <= '0;
            in_idx      <= '0;
            wr_slot     <= '0;
            out_r       <= '0;
            out_c       <= '0;
            out_idx     <= '0;
            out_slot    <= '0;
            sub         <= '0;
        end else begin
            state       <= state_nxt;
            rdy_en      <= 1'b1;
            frame_end_q <= win_adv && last_win;
            if (in_hs) begin
                in_idx <= last_in ? '0 : in_idx + AW'(1);
                if (in_c == LAST_C) begin
                    in_c <= '0;
                    if (in_r == LAST_R) begin
                        in_r    <= '0;
                        wr_slot <= '0;
                    end else begin
                        in_r    <= in_r + RW'(1);
                        wr_slot <= slot_add(wr_slot, 3'd1);
                    end
                end else begin
                    in_c <= in_c + CW'(1);
                end
            end
            if (out_hs) begin
                sub <= (sub == SUB_LAST) ? 4'd0 : sub + 4'd1;
            end
            if (win_adv) begin
                out_idx <= last_win ? '0 : out_idx + AW'(1);
                if (out_c == LAST_C) begin
                    out_c <= '0;
                    if (out_r == LAST_R) begin
                        out_r    <= '0;
                        out_slot <= '0;
                    end else begin
                        out_r    <= out_r + RW'(1);
                        out_slot <= slot_add(out_slot, 3'd1);
                    end
                end else begin
                    out_c <= out_c + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) mem[wr_slot][in_c] <= s_data;
    end

    // Row and column selects for the clamped neighbourhood around (out_r,out_c).
    always_comb begin
        rs[0] = (out_r == '0) ? out_slot : slot_add(out_slot, 3'd4);
        rs[1] = out_slot;
        rs[2] = (out_r == LAST_R) ? out_slot : slot_add(out_slot, 3'd1);
        if (out_r == LAST_R)               rs[3] = out_slot;
        else if (out_r == LAST_R - RW'(1)) rs[3] = slot_add(out_slot, 3'd1);
        else                               rs[3] = slot_add(out_slot, 3'd2);
        cs[0] = (out_c == '0) ? out_c : out_c - CW'(1);
        cs[1] = out_c;
        cs[2] = (out_c == LAST_C) ? out_c : out_c + CW'(1);
        cs[3] = dep_c;
    end

    always_comb begin
        m_win = '0;
        if (m_valid) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    m_win[(4*i+j)*DW +: DW] = mem[rs[i]][cs[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_bicubic_window_buffer.sv
// Self-checking bench for bicubic_window_buffer on a 4x3 image with two handshakes per
// window; pixel value P(r,c) = base + 16*r + c.
`timescale 1ns/1ps
module tb_bicubic_window_buffer;
    localparam int DW   = 24;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int OPW  = 2;
    localparam int NWIN = W * H;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [DW-1:0]    s_data = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [16*DW-1:0] m_win;
    logic [9:0]       m_row, m_col;
    logic [3:0]       m_sub;
    logic             m_frame_end;

    bicubic_window_buffer #(.DW(DW), .IMG_W(W), .IMG_H(H), .OUT_PER_WIN(OPW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win), .m_row(m_row),
        .m_col(m_col), .m_sub(m_sub), .m_frame_end(m_frame_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            r;
        int            c;
        int            k;
        logic [DW-1:0] exp;
    } spot_t;

    spot_t            spots [19];
    int               tests = 0;
    int               fails = 0;
    int               in_count, in_frame, out_k, out_frame, cap_sel;
    bit               fe_flag = 1'b0;
    logic [DW-1:0]    base [4];
    logic [16*DW-1:0] cap [2][NWIN];

    function automatic int clampi(input int x, input int hi);
        if (x < 0) return 0;
        if (x > hi) return hi;
        return x;
    endfunction

    function automatic logic [16*DW-1:0] exp_win(input logic [DW-1:0] b, input int r, input int c);
        logic [16*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[(4*i+j)*DW +: DW] = b + DW'(16 * clampi(r - 1 + i, H - 1) + clampi(c - 1 + j, W - 1));
        return w;
    endfunction

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run(input int nframes, input bit gaps, input bit stall_en, input bit rst_en);
        bit               sv_next = 1'b1, mr_next = 1'b1, snap_ok = 1'b0, stalled = 1'b0, done = 1'b0;
        int               stall_cnt = 0, cyc = 0, wk, r, c, sb, dep;
        logic [511:0]     snap = '0;
        in_count = 0; in_frame = 0; out_k = 0; out_frame = 0;
        while (!done && cyc < 600) begin
            cyc++;
            @(negedge clk);
            s_valid = (in_frame < nframes) ? sv_next : 1'b0;
            s_data  = base[in_frame] + DW'(16 * (in_count / W) + in_count % W);
            m_ready = mr_next;
            #1;
            chk("frame_end", 512'(m_frame_end), 512'(fe_flag));
            fe_flag = 1'b0;
            wk = out_k / OPW; r = wk / W; c = wk % W; sb = out_k % OPW;
            if (m_valid) begin
                dep = clampi(r + 2, H - 1) * W + clampi(c + 2, W - 1);
                chk($sformatf("avail_%0d_%0d", r, c), 512'(m_valid),
                    512'((out_frame < in_frame) || (dep < in_count)));
            end
            if (stall_cnt > 0) begin
                if (m_valid) begin
                    if (!snap_ok) begin
                        snap = 512'({m_win, m_row, m_col, m_sub});
                        snap_ok = 1'b1;
                    end else begin
                        chk("stall_hold", 512'({m_win, m_row, m_col, m_sub}), snap);
                    end
                end
                stall_cnt--;
                if (stall_cnt == 0) begin
                    chk("stall_s_ready", 512'(s_ready), 512'(0));
                    chk("stall_m_valid", 512'(m_valid), 512'(1));
                end
            end
            if (rst_en && m_valid && r == 1 && c == 2 && sb == 0) begin
                rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_m_valid", 512'(m_valid), 512'(0));
                chk("rst_s_ready", 512'(s_ready), 512'(0));
                chk("rst_pos", 512'({m_row, m_col, m_sub}), 512'(0));
                fe_flag = 1'b0;
                done = 1'b1;
            end else begin
                if (m_valid && m_ready) begin
                    chk($sformatf("win_f%0d_%0d_%0d_s%0d", out_frame, r, c, sb),
                        512'({m_row, m_col, m_sub, m_win}),
                        512'({10'(r), 10'(c), 4'(sb), exp_win(base[out_frame], r, c)}));
                    if (out_frame == 1 && wk == 0 && sb == 0)
                        chk("f2_elem0", 512'(m_win[DW-1:0]), 512'(24'h80));
                    if (out_frame == 0 && sb == 0) cap[cap_sel][wk] = m_win;
                    if (stall_en && !stalled && wk == W && sb == OPW - 1) begin
                        stalled = 1'b1;
                        stall_cnt = 10;
                    end
                    out_k++;
                    if (out_k == NWIN * OPW) begin
                        out_k = 0;
                        out_frame++;
                        fe_flag = 1'b1;
                        if (out_frame == nframes) done = 1'b1;
                    end
                end
                if (s_valid && s_ready) begin
                    in_count++;
                    if (in_count == NWIN) begin
                        in_count = 0;
                        in_frame++;
                    end
                end
                mr_next = (stall_cnt == 0);
                sv_next = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got %0d windows done expected %0d frames", out_k / OPW, nframes);
        end
    endtask

    initial begin
        logic [16*DW-1:0] w;
        spots[0]  = '{0, 0, 0,  24'h00};  spots[1]  = '{0, 0, 3,  24'h02};
        spots[2]  = '{0, 0, 5,  24'h00};  spots[3]  = '{0, 0, 10, 24'h11};
        spots[4]  = '{0, 0, 12, 24'h20};  spots[5]  = '{0, 0, 15, 24'h22};
        spots[6]  = '{1, 1, 0,  24'h00};  spots[7]  = '{1, 1, 5,  24'h11};
        spots[8]  = '{1, 1, 7,  24'h13};  spots[9]  = '{1, 1, 15, 24'h23};
        spots[10] = '{2, 3, 0,  24'h12};  spots[11] = '{2, 3, 4,  24'h22};
        spots[12] = '{2, 3, 5,  24'h23};  spots[13] = '{2, 3, 15, 24'h23};
        spots[14] = '{0, 3, 0,  24'h02};  spots[15] = '{0, 3, 8,  24'h12};
        spots[16] = '{0, 3, 11, 24'h13};  spots[17] = '{1, 0, 6,  24'h11};
        spots[18] = '{1, 0, 13, 24'h20};
        base[0] = 24'h00; base[1] = 24'h80; base[2] = 24'h00; base[3] = 24'h00;
        cap_sel = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_m_valid", 512'(m_valid), 512'(0));
        chk("reset_s_ready", 512'(s_ready), 512'(0));
        chk("reset_pos", 512'({m_row, m_col, m_sub}), 512'(0));
        chk("reset_frame_end", 512'(m_frame_end), 512'(0));
        chk("reset_m_win", 512'(m_win), 512'(0));

        run(1, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 19; s++) begin
            w = cap[0][spots[s].r * W + spots[s].c];
            chk($sformatf("spot_%0d_%0d_e%0d", spots[s].r, spots[s].c, spots[s].k),
                512'(w[spots[s].k * DW +: DW]), 512'(spots[s].exp));
        end

        run(1, 1'b0, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b1);
        cap_sel = 1;
        run(1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < NWIN; k++)
            chk($sformatf("post_rst_win%0d", k), 512'(cap[1][k]), 512'(exp_win(24'h00, k / W, k % W)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
